block_ram_reader: RTL and testbench
===================================

BLOCK_RAM_READER -- requirements
Module: block_ram_reader

Interface
REQ-001 SHALL have parameter C_DATA_WIDTH, default 8, RAM word width.
REQ-002 SHALL have parameter C_ADDRESS_WIDTH, default 8, RAM address width; RAM depth is 2**C_ADDRESS_WIDTH.
REQ-003 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request to begin a burst; sampled only in IDLE.
REQ-006 SHALL have port start_addr  input  C_ADDRESS_WIDTH  first word address, sampled with start.
REQ-007 SHALL have port length  input  C_ADDRESS_WIDTH+1  word count, sampled with start; legal range 0..2**C_ADDRESS_WIDTH.
REQ-008 SHALL have port busy  output  1  burst in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse at burst completion.
REQ-010 SHALL have port rd_en  output  1  read strobe to the RAM port.
REQ-011 SHALL have port rd_addr  output  C_ADDRESS_WIDTH  RAM read address, meaningful when rd_en is high.
REQ-012 SHALL have port rd_q  input  C_DATA_WIDTH  RAM read data, valid exactly one cycle after rd_en.
REQ-013 SHALL have port m_valid  output  1  stream data valid.
REQ-014 SHALL have port m_data  output  C_DATA_WIDTH  stream data.
REQ-015 SHALL have port m_last  output  1  marks the final beat of a burst.
REQ-016 SHALL have port m_ready  input  1  downstream accepts the beat when high with m_valid.

Function
REQ-017 SHALL implement states IDLE, RUN, DONE; IDLE->RUN on start with length!=0; IDLE->DONE on start with length==0; RUN->DONE on the handshake of the beat with m_last; DONE->IDLE unconditionally after one cycle.
REQ-018 SHALL ignore start while in RUN or DONE.
REQ-019 SHALL assert busy exactly while in RUN, and done exactly while in DONE.
REQ-020 SHALL issue reads in RUN at addresses start_addr, start_addr+1, ..., modulo 2**C_ADDRESS_WIDTH.
REQ-021 SHALL issue exactly length reads per burst and never more.
REQ-022 SHALL hold a 2-entry output buffer and issue a read in a cycle only if occupancy + reads in flight - (m_valid & m_ready) <= 1, so the buffer never overflows.
REQ-023 SHALL capture rd_q into the buffer on the clock edge that ends the cycle following each rd_en.
REQ-024 SHALL present buffer entries in order; m_data and m_last SHALL hold stable while m_valid is high and m_ready is low.
REQ-025 SHALL NOT deassert m_valid once asserted until the beat is accepted.
REQ-026 SHALL assert m_last only on the beat that is word number length of the burst.
REQ-027 SHALL have latency: start in cycle 0; first rd_en in cycle 1; first m_valid in cycle 3.
REQ-028 SHALL sustain one beat per cycle while m_ready is held high.
REQ-029 SHALL support length == 2**C_ADDRESS_WIDTH as a full wrap over the whole RAM with no repeated address.
REQ-030 SHALL produce no rd_en and no m_valid for length == 0, only the done pulse.

Reset
REQ-031 SHALL on reset assertion, at any time, immediately force state IDLE and drive busy=0, done=0, rd_en=0, m_valid=0, m_last=0, rd_addr=0, m_data=0.
REQ-032 SHALL on reset discard buffer contents and in-flight reads, and SHALL NOT produce a done pulse for the aborted burst.
REQ-033 SHALL accept start on the first clock edge after reset deasserts.

Verification
REQ-034 Test 1: RAM[i]=i, start_addr=0x10, length=4, m_ready=1 -> rd_en in cycles 1-4, beats 0x10..0x13 in cycles 3-6, m_last on 0x13, done in cycle 7.
REQ-035 Test 2: start_addr=0xFE, length=4 -> addresses and data 0xFE,0xFF,0x00,0x01 in order.
REQ-036 Test 3: length=16, m_ready randomly toggled -> 16 beats in order, no drop or duplicate, data stable while stalled, at most 2 reads outstanding beyond accepted beats.
REQ-037 Test 4: length=0 -> done pulse in cycle 1, no rd_en, no m_valid; length=256 -> 256 beats, every address once.
REQ-038 Test 5: reset asserted mid-burst after 3 beats -> outputs zero the same cycle, no done; new burst after reset streams correctly from its own start_addr.
REQ-039 Test 6: start pulsed again during RUN -> ignored; beat count equals the original length.

Source files
------------

// File: rtl/block_ram_reader.sv
// Burst reader: streams `length` consecutive words from a 1-cycle-latency block RAM
// onto a valid/ready stream through a 2-entry skid buffer.
module block_ram_reader #(
  parameter int C_DATA_WIDTH    = 8,
  parameter int C_ADDRESS_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [C_ADDRESS_WIDTH-1:0] start_addr,
  input  logic [C_ADDRESS_WIDTH:0]   length,
  output logic                       busy,
  output logic                       done,
  output logic                       rd_en,
  output logic [C_ADDRESS_WIDTH-1:0] rd_addr,
  input  logic [C_DATA_WIDTH-1:0]    rd_q,
  output logic                       m_valid,
  output logic [C_DATA_WIDTH-1:0]    m_data,
  output logic                       m_last,
  input  logic                       m_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [C_ADDRESS_WIDTH-1:0] C_ADDR_ONE = 1;
  localparam logic [C_ADDRESS_WIDTH:0]   C_LEN_ONE  = 1;

  state_t                     r_state;
  logic [C_ADDRESS_WIDTH-1:0] r_rd_addr;
  logic [C_ADDRESS_WIDTH:0]   r_reads_left;
  logic                       r_inflight;
  logic                       r_inflight_last;
  logic [C_DATA_WIDTH-1:0]    r_buf_data [2];
  logic [1:0]                 r_buf_last;
  logic                       r_wr_ptr;
  logic                       r_rd_ptr;
  logic [1:0]                 r_count;

  logic       w_push;
  logic       w_pop;
  logic [2:0] w_level;
  logic       w_rd_en;

  // Occupancy the buffer will reach once every read already issued has landed;
  // a new read is only allowed while that leaves room for its data.
  assign w_push  = r_inflight;
  assign w_pop   = m_valid & m_ready;
  assign w_level = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_rd_en = (r_state == RUN) && (r_reads_left != '0) && (w_level <= 3'd1);

  assign busy    = (r_state == RUN);
  assign done    = (r_state == DONE);
  assign rd_en   = w_rd_en;
  assign rd_addr = r_rd_addr;
  assign m_valid = (r_count != 2'd0);
  assign m_data  = r_buf_data[r_rd_ptr];
  assign m_last  = m_valid & r_buf_last[r_rd_ptr];

  // NOTE: the buffer storage sits in the reset branch on purpose: m_data is read
  // straight from it and must show zero while reset is held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= IDLE;
      r_rd_addr       <= '0;
      r_reads_left    <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_buf_data[0]   <= '0;
      r_buf_data[1]   <= '0;
      r_buf_last      <= '0;
      r_wr_ptr        <= 1'b0;
      r_rd_ptr        <= 1'b0;
      r_count         <= '0;
    end else begin
      r_inflight      <= w_rd_en;
      r_inflight_last <= w_rd_en && (r_reads_left == C_LEN_ONE);

      if (w_push) begin
        r_buf_data[r_wr_ptr] <= rd_q;
        r_buf_last[r_wr_ptr] <= r_inflight_last;
        r_wr_ptr             <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};

      case (r_state)
        IDLE: begin
          if (start) begin
            r_rd_addr    <= start_addr;
            r_reads_left <= length;
            r_state      <= (length == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (w_rd_en) begin
            r_rd_addr    <= r_rd_addr + C_ADDR_ONE;
            r_reads_left <= r_reads_left - C_LEN_ONE;
          end
          if (w_pop && r_buf_last[r_rd_ptr]) begin
            r_state <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_block_ram_reader.sv
// Directed bench for block_ram_reader: a queue of expected beats built from the RAM
// image at start time is compared against the stream every cycle.
module tb_block_ram_reader;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] start_addr;
  logic [8:0] length;
  logic       busy, done, rd_en, m_valid, m_last;
  logic [7:0] rd_addr, m_data;
  logic [7:0] rd_q;
  logic       m_ready = 1'b1;

  block_ram_reader #(.C_DATA_WIDTH(8), .C_ADDRESS_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr), .length(length),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_q(rd_q),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // RAM with one cycle of read latency
  logic [7:0] mem [256];
  logic       pend_en = 1'b0;
  logic [7:0] pend_addr;
  always @(negedge clk) begin
    pend_en   = rd_en;
    pend_addr = rd_addr;
  end
  always @(posedge clk) begin
    #1;
    rd_q = pend_en ? mem[pend_addr] : 8'h00;
  end

  int rdy_mode = 0;
  always @(posedge clk) begin
    #1;
    m_ready = (rdy_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Behavioural model
  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } beat_t;

  beat_t      q[$];
  logic [7:0] acc_log[$];
  bit         exp_busy = 0, exp_done = 0;
  int         exp_len = 0, issued = 0, accepted = 0, vcount = 0, dup_cnt = 0;
  logic [7:0] exp_addr = 8'h00;
  int         start_cyc = 0, first_rd_rel = -1, last_rd_rel = -1, first_v_rel = -1, done_rel = -1;
  bit         seen [256];
  bit         prev_stall = 0;
  logic [7:0] prev_data;
  logic       prev_last;

  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      exp_busy   = 0;
      exp_done   = 0;
      exp_len    = 0;
      issued     = 0;
      accepted   = 0;
      prev_stall = 0;
    end else begin
      bit last_acc;
      last_acc = 0;
      check("busy", busy, exp_busy);
      check("done", done, exp_done);
      if (done) done_rel = cyc - start_cyc;

      if (rd_en) begin
        check("rd_addr", rd_addr, exp_addr);
        check("rd_within_len", issued < exp_len, 1);
        if (seen[rd_addr]) dup_cnt++;
        seen[rd_addr] = 1;
        if (first_rd_rel < 0) first_rd_rel = cyc - start_cyc;
        last_rd_rel = cyc - start_cyc;
        issued++;
        exp_addr++;
      end

      if (m_valid) begin
        if (first_v_rel < 0) first_v_rel = cyc - start_cyc;
        vcount++;
        check("beat_expected", q.size() != 0, 1);
        if (q.size() != 0) begin
          check("m_data", m_data, q[0].d);
          check("m_last", m_last, q[0].l);
        end
        if (prev_stall) begin
          check("stall_data", m_data, prev_data);
          check("stall_last", m_last, prev_last);
        end
      end else if (prev_stall) begin
        check("valid_held", m_valid, 1);
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;

      if (m_valid && m_ready && q.size() != 0) begin
        last_acc = q[0].l;
        acc_log.push_back(m_data);
        void'(q.pop_front());
        accepted++;
      end
      if (exp_busy) check("outstanding", (issued - accepted) <= 2, 1);

      if (exp_done) begin
        exp_done = 0;
      end else if (exp_busy) begin
        if (last_acc) begin
          exp_busy = 0;
          exp_done = 1;
        end
      end else if (start) begin
        exp_len      = int'(length);
        exp_addr     = start_addr;
        issued       = 0;
        accepted     = 0;
        vcount       = 0;
        dup_cnt      = 0;
        start_cyc    = cyc;
        first_rd_rel = -1;
        last_rd_rel  = -1;
        first_v_rel  = -1;
        done_rel     = -1;
        for (int i = 0; i < 256; i++) seen[i] = 0;
        acc_log.delete();
        q.delete();
        for (int i = 0; i < exp_len; i++)
          q.push_back('{d: mem[(int'(start_addr) + i) % 256], l: (i == exp_len - 1)});
        if (exp_len == 0) exp_done = 1;
        else exp_busy = 1;
      end
    end
  end

  // Caller is mid-cycle; start is sampled on the next rising edge.
  task automatic do_start(input logic [7:0] a, input logic [8:0] n);
    start      = 1'b1;
    start_addr = a;
    length     = n;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 3000);
    check(name, n < 3000, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp2 [4];
    int cnt;
    reset = 1'b1; start = 1'b0; start_addr = '0; length = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);

    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last", m_last, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_m_data", m_data, 0);

    // Test 1: start accepted on the first edge after reset release
    @(posedge clk);
    #1 reset = 1'b0;
    do_start(8'h10, 9'd4);
    wait_done("t1_timeout");
    check("t1_first_rd", first_rd_rel, 1);
    check("t1_last_rd", last_rd_rel, 4);
    check("t1_reads", issued, 4);
    check("t1_first_valid", first_v_rel, 3);
    check("t1_done_cycle", done_rel, 7);
    check("t1_beats", accepted, 4);
    for (int i = 0; i < 4; i++) check("t1_data", acc_log[i], 32'h10 + i);

    // Test 2: address wrap
    do_start(8'hFE, 9'd4);
    wait_done("t2_timeout");
    exp2 = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    check("t2_beats", accepted, 4);
    for (int i = 0; i < 4; i++) check("t2_data", acc_log[i], exp2[i]);

    // Test 3: random back-pressure over a scrambled image
    for (int i = 0; i < 256; i++) mem[i] = {i[3:0], i[7:4]} ^ 8'hA5;
    rdy_mode = 1;
    do_start(8'h30, 9'd16);
    wait_done("t3_timeout");
    rdy_mode = 0;
    check("t3_beats", accepted, 16);
    check("t3_reads", issued, 16);

    // Test 4: zero length, then full wrap
    do_start(8'h55, 9'd0);
    wait_done("t4a_timeout");
    check("t4a_done_cycle", done_rel, 1);
    check("t4a_reads", issued, 0);
    check("t4a_valids", vcount, 0);
    do_start(8'h37, 9'd256);
    wait_done("t4b_timeout");
    check("t4b_reads", issued, 256);
    check("t4b_beats", accepted, 256);
    check("t4b_dups", dup_cnt, 0);
    cnt = 0;
    for (int i = 0; i < 256; i++) cnt += int'(seen[i]);
    check("t4b_coverage", cnt, 256);

    // Test 5: reset in the middle of a burst
    do_start(8'h40, 9'd16);
    cnt = 0;
    while (accepted < 3 && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    check("t5_wait", cnt < 100, 1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("t5_busy", busy, 0);
    check("t5_done", done, 0);
    check("t5_rd_en", rd_en, 0);
    check("t5_m_valid", m_valid, 0);
    check("t5_m_last", m_last, 0);
    check("t5_rd_addr", rd_addr, 0);
    check("t5_m_data", m_data, 0);
    @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      cnt += int'(done);
    end
    check("t5_no_done", cnt, 0);
    @(posedge clk);
    #1;
    do_start(8'h80, 9'd5);
    wait_done("t5_timeout");
    check("t5_beats", accepted, 5);
    check("t5_first", acc_log[0], mem[8'h80]);

    // Test 6: start re-pulsed while running is ignored
    do_start(8'h20, 9'd8);
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1; start_addr = 8'h00; length = 9'd3;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("t6_timeout");
    check("t6_beats", accepted, 8);
    check("t6_reads", issued, 8);
    check("t6_first", acc_log[0], mem[8'h20]);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
